// File: rtl/key_switch_filter.sv
// -----------------------------------------------------------------------------
// key_switch_filter
//
// Input conditioning ahead of the three-colour lamp controller. Both raw board
// keys are synchronised and debounced. Each debounced press becomes a
// single-cycle event. These events drive a two-state virtual wall switch:
// Key[0] toggles it and Key[1] forces it off.
//
// Parameters
//   DEBOUNCE_CNT : consecutive stable cycles needed to accept a level change
//   CNT_W        : debounce counter width, 2**CNT_W must exceed DEBOUNCE_CNT
//
// Ports
//   Sys_CLK      in  1 : system clock
//   Sys_RST      in  1 : synchronous reset, active low
//   Key          in  2 : raw push-buttons, active low, asynchronous, bouncing
//   key_state    out 2 : debounced level per key, 1 = pressed
//   press_pulse  out 2 : one-cycle pulse per key on each debounced press
//   fake_switch  out 1 : virtual switch level, 1 = on
// -----------------------------------------------------------------------------
module key_switch_filter #(
   parameter int DEBOUNCE_CNT = 250000,
   parameter int CNT_W        = 18
) (
   input  logic       Sys_CLK,
   input  logic       Sys_RST,
   input  logic [1:0] Key,
   output logic [1:0] key_state,
   output logic [1:0] press_pulse,
   output logic       fake_switch
);

   // The commit fires on the cycle where the count would reach DEBOUNCE_CNT.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   // Two-flop synchroniser. It resets to released (1) so that no reset
   // artefact can appear as a press.
   logic [1:0] sync1_reg;
   logic [1:0] sync2_reg;

   always_ff @(posedge Sys_CLK) begin
      if (!Sys_RST) begin
         sync1_reg <= 2'b11;
         sync2_reg <= 2'b11;
      end else begin
         sync1_reg <= Key;
         sync2_reg <= sync1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_key
         logic             stable_reg;
         logic [CNT_W-1:0] cnt_reg;
         logic             pulse_reg;

         // Any cycle in which the input agrees with the committed level
         // restarts the count, so a bounce shorter than DEBOUNCE_CNT never
         // commits. The counter clears on commit and therefore never wraps.
         always_ff @(posedge Sys_CLK) begin
            if (!Sys_RST) begin
               stable_reg <= 1'b1;
               cnt_reg    <= '0;
               pulse_reg  <= 1'b0;
            end else begin
               pulse_reg <= 1'b0;
               if (sync2_reg[gi] == stable_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  stable_reg <= sync2_reg[gi];
                  cnt_reg    <= '0;
                  // Only a commit to the low (pressed) level raises an event.
                  pulse_reg  <= ~sync2_reg[gi];
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign key_state[gi]   = ~stable_reg;
         assign press_pulse[gi] = pulse_reg;
      end
   endgenerate

   // Virtual switch. When both keys press together, force-off wins.
   typedef enum logic {
      ST_OFF = 1'b0,
      ST_ON  = 1'b1
   } sw_state_t;

   sw_state_t state_reg;
   sw_state_t state_next;

   always_ff @(posedge Sys_CLK) begin
      if (!Sys_RST) begin
         state_reg <= ST_OFF;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_OFF: begin
            if (press_pulse[0] && !press_pulse[1]) begin
               state_next = ST_ON;
            end
         end
         ST_ON: begin
            if (press_pulse[0] || press_pulse[1]) begin
               state_next = ST_OFF;
            end
         end
         default: state_next = ST_OFF;
      endcase
   end

   assign fake_switch = (state_reg == ST_ON);

endmodule
